// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalisation LUT controller:
// FSM encoding, level/count widths and the count-to-grey scaling helper.
package hist_eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_DONE  = 2'd2
  } fsm_state_e;

  localparam int LEVELS       = 256;
  localparam int LEVEL_W      = $clog2(LEVELS);
  localparam int ACC_W        = 20;
  localparam int SCALE_W      = 24;
  localparam int PROD_W       = ACC_W + SCALE_W;
  localparam int SCALE_SH_DEF = 16;

  // Build-pipeline stage-1 payload: one accepted histogram beat.
  typedef struct packed {
    logic               valid;
    logic [LEVEL_W-1:0] level;
    logic [PROD_W-1:0]  prod;
  } wr_stage_t;

  // Drop the fixed-point fraction and clamp to the top grey level.
  function automatic logic [LEVEL_W-1:0] sat_map(input logic [PROD_W-1:0] prod,
                                                 input int              sh);
    logic [PROD_W-1:0] whole;
    whole = prod >> sh;
    return (|whole[PROD_W-1:LEVEL_W]) ? {LEVEL_W{1'b1}} : whole[LEVEL_W-1:0];
  endfunction

endpackage

// File: rtl/ram_dual_port.sv
// Simple dual-port RAM: port A write-only, port B read-only with a
// registered read (one cycle latency).
module ram_dual_port #(
  parameter int C_ADDR_WIDTH = 9,
  parameter int C_DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    we_a_i,
  input  logic [C_ADDR_WIDTH-1:0] addr_a_i,
  input  logic [C_DATA_WIDTH-1:0] din_a_i,
  input  logic [C_ADDR_WIDTH-1:0] addr_b_i,
  output logic [C_DATA_WIDTH-1:0] dout_b_o
);

  logic [C_DATA_WIDTH-1:0] mem_q [2**C_ADDR_WIDTH];
  logic [C_DATA_WIDTH-1:0] rd_q;

  // NOTE: the array has no reset; a reset loop over every word would stop it
  // mapping onto block RAM, and the controller never reads a bank it has not filled.
  always_ff @(posedge clk) begin
    if (we_a_i) begin
      mem_q[addr_a_i] <= din_a_i;
    end
    rd_q <= mem_q[addr_b_i];
  end

  assign dout_b_o = rd_q;

endmodule

// File: rtl/hist_eq_lut_ctrl.sv
// Histogram-equalisation LUT controller: builds a mapping table from the
// cumulative histogram into the idle bank, swaps banks on frame start and
// remaps the live pixel stream through the active bank.
module hist_eq_lut_ctrl
  import hist_eq_pkg::*;
#(
  parameter int IMG_PIXELS = 307200,
  parameter int SCALE_SH   = SCALE_SH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LEVEL_W-1:0] pixel_level,
  input  logic [ACC_W-1:0]   pixel_level_acc_num,
  input  logic               pixel_level_valid,
  input  logic               img_vsync,
  input  logic               img_href,
  input  logic [LEVEL_W-1:0] img_gray,
  output logic               post_vsync,
  output logic               post_href,
  output logic [LEVEL_W-1:0] post_gray,
  output logic               lut_ready,
  output logic               active_bank,
  output logic               build_err
);

  localparam logic [SCALE_W-1:0] SCALE =
    SCALE_W'((longint'(255) << SCALE_SH) / longint'(IMG_PIXELS));

  fsm_state_e         state_q;
  logic [LEVEL_W-1:0] prev_level_q;
  logic               build_err_q;
  logic               lut_ready_q;
  logic               active_bank_q;

  wr_stage_t          wr_q;

  logic               vsync_d1_q;
  logic               href_d1_q;
  logic [LEVEL_W-1:0] gray_d1_q;
  logic               ready_d1_q;
  logic               post_vsync_q;
  logic               post_href_q;
  logic [LEVEL_W-1:0] post_gray_q;

  logic               level_seq;
  logic               wr_accept;
  logic               vsync_rise;
  logic [LEVEL_W-1:0] lut_dout;

  assign vsync_rise = img_vsync & ~vsync_d1_q;

  // A beat is written only if it belongs to a table being built: level 0
  // opens (or restarts) a build, later levels must follow in sequence.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    level_seq = ({1'b0, pixel_level} == ({1'b0, prev_level_q} + 9'd1));
    wr_accept = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: wr_accept = pixel_level_valid && (pixel_level == '0);
      ST_BUILD:         wr_accept = pixel_level_valid && (level_seq || pixel_level == '0);
      default:          wr_accept = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      prev_level_q  <= '0;
      build_err_q   <= 1'b0;
      lut_ready_q   <= 1'b0;
      active_bank_q <= 1'b0;
    end else begin
      build_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (wr_accept) begin
            state_q      <= ST_BUILD;
            prev_level_q <= '0;
          end
        end
        ST_BUILD: begin
          if (wr_accept) begin
            prev_level_q <= pixel_level;
            if (pixel_level == {LEVEL_W{1'b1}}) begin
              state_q <= ST_DONE;
            end
          end else begin
            build_err_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (vsync_rise) begin
            active_bank_q <= ~active_bank_q;
            lut_ready_q   <= 1'b1;
            state_q       <= ST_IDLE;
          end
          // A fresh level-0 beat starts the next table; it wins over IDLE.
          if (wr_accept) begin
            state_q      <= ST_BUILD;
            prev_level_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Build pipeline stage 1: scale the count; stage 2 is the RAM write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
    end else begin
      wr_q.valid <= wr_accept;
      wr_q.level <= pixel_level;
      wr_q.prod  <= PROD_W'(pixel_level_acc_num) * PROD_W'(SCALE);
    end
  end

  ram_dual_port #(
    .C_ADDR_WIDTH(LEVEL_W + 1),
    .C_DATA_WIDTH(LEVEL_W)
  ) u_lut_ram (
    .clk     (clk),
    .we_a_i  (wr_q.valid),
    .addr_a_i({~active_bank_q, wr_q.level}),
    .din_a_i (sat_map(wr_q.prod, SCALE_SH)),
    .addr_b_i({active_bank_q, img_gray}),
    .dout_b_o(lut_dout)
  );

  // Map pipe: ready travels with the read so a swap edge cannot pair a
  // lookup from the old bank with the new ready state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d1_q   <= 1'b0;
      href_d1_q    <= 1'b0;
      gray_d1_q    <= '0;
      ready_d1_q   <= 1'b0;
      post_vsync_q <= 1'b0;
      post_href_q  <= 1'b0;
      post_gray_q  <= '0;
    end else begin
      vsync_d1_q   <= img_vsync;
      href_d1_q    <= img_href;
      gray_d1_q    <= img_gray;
      ready_d1_q   <= lut_ready_q;
      post_vsync_q <= vsync_d1_q;
      post_href_q  <= href_d1_q;
      if (!href_d1_q) begin
        post_gray_q <= '0;
      end else if (ready_d1_q) begin
        post_gray_q <= lut_dout;
      end else begin
        post_gray_q <= gray_d1_q;
      end
    end
  end

  assign post_vsync  = post_vsync_q;
  assign post_href   = post_href_q;
  assign post_gray   = post_gray_q;
  assign lut_ready   = lut_ready_q;
  assign active_bank = active_bank_q;
  assign build_err   = build_err_q;

endmodule

// File: tb/tb_hist_eq_lut_ctrl.sv
// Self-checking bench for hist_eq_lut_ctrl: directed frame/build sequences
// with random counts and pixels, checked against a table-level reference.
module tb_hist_eq_lut_ctrl;

  localparam int     IMG_PIXELS_TB = 256;
  localparam int     SH            = 16;
  localparam longint SCALE_REF     = (longint'(255) << SH) / IMG_PIXELS_TB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  pixel_level = '0;
  logic [19:0] pixel_level_acc_num = '0;
  logic        pixel_level_valid = 1'b0;
  logic        img_vsync = 1'b0;
  logic        img_href = 1'b0;
  logic [7:0]  img_gray = '0;
  logic        post_vsync;
  logic        post_href;
  logic [7:0]  post_gray;
  logic        lut_ready;
  logic        active_bank;
  logic        build_err;

  always #5 clk = ~clk;

  hist_eq_lut_ctrl #(
    .IMG_PIXELS(IMG_PIXELS_TB),
    .SCALE_SH  (SH)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .pixel_level        (pixel_level),
    .pixel_level_acc_num(pixel_level_acc_num),
    .pixel_level_valid  (pixel_level_valid),
    .img_vsync          (img_vsync),
    .img_href           (img_href),
    .img_gray           (img_gray),
    .post_vsync         (post_vsync),
    .post_href          (post_href),
    .post_gray          (post_gray),
    .lut_ready          (lut_ready),
    .active_bank        (active_bank),
    .build_err          (build_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: the table in use, the one being assembled, the one waiting
  // for a frame start, plus which bank should be live.
  logic [7:0] tbl_active [256];
  logic [7:0] tbl_build  [256];
  logic [7:0] tbl_pend   [256];
  bit         m_ready = 1'b0;
  bit         m_bank  = 1'b0;
  bit         m_pend  = 1'b0;
  logic [9:0] exp_q [$];

  function automatic logic [7:0] ref_map(input int unsigned acc);
    longint p;
    p = (longint'(acc) * SCALE_REF) >>> SH;
    return (p > 255) ? 8'd255 : 8'(p);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record what the current pixel should become two clocks on,
  // then compare the output due now.
  task automatic cycle();
    logic [9:0] e;
    e = {img_vsync, img_href,
         img_href ? (m_ready ? tbl_active[img_gray] : img_gray) : 8'h00};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("map", {22'd0, post_vsync, post_href, post_gray}, {22'd0, e});
    end
  endtask

  task automatic pix();
    img_href = ($urandom_range(0, 3) != 0);
    img_gray = 8'($urandom);
    cycle();
  endtask

  task automatic beat(input int l, input int unsigned acc);
    pixel_level         = 8'(l);
    pixel_level_acc_num = 20'(acc);
    pixel_level_valid   = 1'b1;
    tbl_build[l]        = ref_map(acc);
    if (l == 0) m_pend = 1'b0;
    pix();
  endtask

  // mode 0: random counts, 1: ramp acc=level+1, 2: random with vsync rising on level 255
  task automatic build(input int mode);
    for (int l = 0; l < 256; l++) begin
      if (mode == 2 && l == 255) img_vsync = 1'b1;
      beat(l, (mode == 1) ? 32'(l + 1) : $urandom_range(0, 400));
      check("build_err_idle", {31'd0, build_err}, 32'd0);
    end
    pixel_level_valid = 1'b0;
    tbl_pend = tbl_build;
    m_pend   = 1'b1;
  endtask

  task automatic frame_start();
    img_vsync = 1'b1;
    pix();
    if (m_pend) begin
      m_bank     = ~m_bank;
      m_ready    = 1'b1;
      tbl_active = tbl_pend;
      m_pend     = 1'b0;
    end
    check("active_bank", {31'd0, active_bank}, {31'd0, m_bank});
    check("lut_ready",   {31'd0, lut_ready},   {31'd0, m_ready});
  endtask

  task automatic frame_end();
    img_vsync = 1'b0;
    pix();
  endtask

  task automatic map_random(input int n);
    for (int i = 0; i < n; i++) pix();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {19'd0, post_vsync, post_href, post_gray, lut_ready, active_bank, build_err}, 32'd0);
    rst_n = 1'b1;

    // 1: no table yet, pixels pass straight through; href low gives 0
    frame_start();
    img_href = 1'b1;
    img_gray = 8'h40;
    repeat (6) cycle();
    img_href = 1'b0;
    img_gray = 8'h77;
    repeat (3) cycle();
    check("t1_ready", {31'd0, lut_ready}, 32'd0);
    frame_end();

    // 2: ramp table, identity-like mapping after the swap
    build(1);
    frame_start();
    check("t2_bank", {31'd0, active_bank}, 32'd1);
    check("t2_ready", {31'd0, lut_ready}, 32'd1);
    img_href = 1'b1;
    img_gray = 8'd0;   cycle();
    img_gray = 8'd255; cycle();
    img_gray = 8'd127; cycle();
    map_random(40);
    frame_end();

    // 3: stream drops valid at level 100 -> error pulse, no swap
    for (int l = 0; l < 100; l++) beat(l, $urandom_range(0, 400));
    pixel_level_valid = 1'b0;
    pix();
    check("t3_err_pulse", {31'd0, build_err}, 32'd1);
    pix();
    check("t3_err_clear", {31'd0, build_err}, 32'd0);
    frame_start();
    check("t3_bank_kept", {31'd0, active_bank}, 32'd1);
    map_random(30);

    // Out-of-order level -> error; level 0 mid-build -> silent restart
    for (int l = 0; l <= 10; l++) beat(l, $urandom_range(0, 400));
    beat(20, $urandom_range(0, 400));
    check("t3_wrong_level_err", {31'd0, build_err}, 32'd1);
    for (int l = 0; l <= 30; l++) beat(l, $urandom_range(0, 400));
    build(0);
    frame_end();
    frame_start();
    check("t5_bank_b", {31'd0, active_bank}, 32'd0);
    map_random(40);

    // 5: next build across frames -> bank alternates again
    frame_end();
    build(0);
    frame_start();
    check("t5_bank_c", {31'd0, active_bank}, 32'd1);
    map_random(40);
    frame_end();

    // 4: level-255 write coinciding with vsync rise -> swap waits for next rise
    build(2);
    check("t4_no_swap", {31'd0, active_bank}, 32'd1);
    map_random(10);
    check("t4_still_no_swap", {31'd0, active_bank}, 32'd1);
    frame_end();
    frame_start();
    check("t4_swap_next_rise", {31'd0, active_bank}, 32'd0);
    map_random(30);
    frame_end();

    // 6: reset in the middle of a build
    build(0);
    frame_start();
    map_random(10);
    frame_end();
    for (int l = 0; l < 50; l++) beat(l, $urandom_range(0, 400));
    pixel_level         = 8'd50;
    pixel_level_acc_num = 20'd77;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_reset_outs", {19'd0, post_vsync, post_href, post_gray, lut_ready, active_bank, build_err}, 32'd0);
    exp_q.delete();
    m_ready = 1'b0;
    m_bank  = 1'b0;
    m_pend  = 1'b0;
    pixel_level_valid = 1'b0;
    img_vsync = 1'b0;
    img_href  = 1'b0;
    rst_n = 1'b1;
    pix();
    build(0);
    frame_start();
    check("t6_bank", {31'd0, active_bank}, 32'd1);
    check("t6_ready", {31'd0, lut_ready}, 32'd1);
    map_random(40);
    frame_end();
    img_href = 1'b0;
    repeat (2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
